// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 framing constants, receiver state encoding
// and the bit-period helper. The transmitter uses the same constants.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // System clocks per serial bit; the result must lie in 4..65535 so the
  // 16-bit bit-period counter and the half-bit start check both work.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. The reset value is a
// parameter so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg <= {2{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the serial line, validates the start bit at
// mid-bit, samples eight data bits LSB first at their centres, checks the stop
// bit, and reports either a one-cycle rx_valid pulse or a frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  // Bit timing derived from the clock and baud rate; clks_per_bit must be
  // between 4 and 65535 for the 16-bit counter.
  localparam int clks_per_bit = calc_clks_per_bit(clk_freq, baud_rate);
  localparam int half_bit     = clks_per_bit / 2;

  localparam logic [15:0] bit_last   = 16'(clks_per_bit - 1);
  localparam logic [15:0] half_last  = 16'(half_bit - 1);
  localparam logic [2:0]  index_last = 3'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_reg;
  logic [15:0]          clk_count_reg;
  logic [2:0]           bit_index_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 rx_valid_reg;
  logic                 rx_busy_reg;
  logic                 frame_err_reg;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_line),
    .q       (rx_s)
  );

  // Frame state machine; every output is registered and the two pulses
  // default low so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      clk_count_reg <= 16'd0;
      bit_index_reg <= 3'd0;
      shift_reg     <= '0;
      data_reg      <= '0;
      rx_valid_reg  <= 1'b0;
      rx_busy_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          rx_busy_reg   <= 1'b0;
          clk_count_reg <= 16'd0;
          if (rx_s == START_BIT) begin
            state_reg   <= START;
            rx_busy_reg <= 1'b1;
          end
        end

        START: begin
          if (clk_count_reg == half_last) begin
            clk_count_reg <= 16'd0;
            bit_index_reg <= 3'd0;
            if (rx_s == START_BIT) begin
              state_reg <= DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_reg   <= IDLE;
              rx_busy_reg <= 1'b0;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        DATA: begin
          if (clk_count_reg == bit_last) begin
            clk_count_reg <= 16'd0;
            shift_reg     <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_index_reg == index_last) begin
              bit_index_reg <= 3'd0;
              state_reg     <= STOP;
            end else begin
              bit_index_reg <= bit_index_reg + 3'd1;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        STOP: begin
          if (clk_count_reg == bit_last) begin
            clk_count_reg <= 16'd0;
            if (rx_s == STOP_BIT) begin
              // Back to IDLE at mid stop bit so a back-to-back start is caught.
              data_reg     <= shift_reg;
              rx_valid_reg <= 1'b1;
              rx_busy_reg  <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_IDLE;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        WAIT_IDLE: begin
          // A held-low (break) line must not be mistaken for a new start bit.
          if (rx_s == STOP_BIT) begin
            state_reg   <= IDLE;
            rx_busy_reg <= 1'b0;
          end
        end

        default: begin
          state_reg   <= IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_busy   = rx_busy_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (half bit = 8).
module tb_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       rx_line;
  logic [7:0] data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int n_pass  = 0;
  int n_total = 0;

  int cycle = 0;
  int valid_count = 0;
  int ferr_count = 0;
  int both_count = 0;
  int valid_busy_low = 0;
  int last_vc = 0;
  int prev_vc = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rx_q[$];

  uart_rx #(
    .clk_freq  (16),
    .baud_rate (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_line   (rx_line),
    .data      (data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_count++;
      prev_data = last_data;
      last_data = data;
      prev_vc   = last_vc;
      last_vc   = cycle;
      rx_q.push_back(data);
      if (rx_busy === 1'b0) valid_busy_low++;
    end
    if (frame_err === 1'b1) ferr_count++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    $display("tx frame byte=%02h stop=%0b at cycle %0d", b, stop, cycle);
    rx_line = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      tick(16);
    end
    rx_line = stop;
    tick(16);
  endtask

  initial begin
    int vc0;
    int fc0;
    int start_c;
    int lat;
    int busy_cycles;
    int mism;

    // Reset and idle
    reset_n = 1'b0;
    rx_line = 1'b1;
    tick(3);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(rx_busy), 32'h0);

    // Single byte A5
    vc0 = valid_count;
    fc0 = ferr_count;
    start_c = cycle;
    send_frame(8'hA5, 1'b1);
    tick(20);
    lat = last_vc - start_c;
    check("a5_valid_count", 32'(valid_count - vc0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_no_ferr", 32'(ferr_count - fc0), 32'd0);
    check("a5_busy_low_with_valid", 32'(valid_busy_low), 32'd1);
    check("a5_latency_153_155", 32'(lat >= 153 && lat <= 155), 32'd1);

    // Back-to-back 00 then FF
    vc0 = valid_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    check("b2b_valid_count", 32'(valid_count - vc0), 32'd2);
    check("b2b_first_data", 32'(prev_data), 32'h00);
    check("b2b_second_data", 32'(last_data), 32'hFF);
    check("b2b_spacing", 32'(last_vc - prev_vc), 32'd160);

    // Glitch rejection: 4 low cycles
    vc0 = valid_count;
    fc0 = ferr_count;
    busy_cycles = 0;
    $display("tx glitch 4 cycles at cycle %0d", cycle);
    rx_line = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (rx_busy === 1'b1) busy_cycles++;
    end
    rx_line = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (rx_busy === 1'b1) busy_cycles++;
    end
    check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
    check("glitch_busy_low_by_11", 32'(rx_busy), 32'h0);
    tick(30);
    check("glitch_no_valid", 32'(valid_count - vc0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_count - fc0), 32'd0);

    // Framing error on 3C, then line held low 40 more cycles
    vc0 = valid_count;
    fc0 = ferr_count;
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("ferr_busy_held", 32'(rx_busy), 32'h1);
    check("ferr_count", 32'(ferr_count - fc0), 32'd1);
    check("ferr_data_kept", 32'(data), 32'hFF);
    rx_line = 1'b1;
    tick(6);
    check("ferr_busy_released", 32'(rx_busy), 32'h0);
    tick(30);
    check("ferr_no_spurious_valid", 32'(valid_count - vc0), 32'd0);
    send_frame(8'h42, 1'b1);
    tick(20);
    check("after_ferr_valid", 32'(valid_count - vc0), 32'd1);
    check("after_ferr_data", 32'(data), 32'h42);
    check("never_both_pulses", 32'(both_count), 32'd0);

    // Reset during data bit 4 of 81
    vc0 = valid_count;
    $display("tx partial frame byte=81 with reset at cycle %0d", cycle);
    rx_line = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx_line = (i == 0) ? 1'b1 : 1'b0;
      tick(16);
    end
    rx_line = 1'b0;
    tick(8);
    reset_n = 1'b0;
    tick(1);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_valid", 32'(rx_valid), 32'h0);
    check("midreset_busy", 32'(rx_busy), 32'h0);
    check("midreset_ferr", 32'(frame_err), 32'h0);
    rx_line = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(200);
    check("midreset_no_valid", 32'(valid_count - vc0), 32'd0);
    send_frame(8'h81, 1'b1);
    tick(20);
    check("postreset_valid", 32'(valid_count - vc0), 32'd1);
    check("postreset_data", 32'(data), 32'h81);

    // Loopback of 256 sequential bytes
    rx_q.delete();
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1);
    end
    tick(20);
    mism = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 8'(i)) mism++;
    end
    check("loop_count", 32'(rx_q.size()), 32'd256);
    check("loop_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter. Same framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Synchronises the asynchronous serial line, detects and validates the start bit, samples each bit at mid-bit, and presents the byte with a one-cycle valid pulse.
- Flags framing errors.
- Sits between the board RX pin and any byte consumer (FIFO, command parser).

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate.
- Derived localparams, not overridable:
  - clks_per_bit = clk_freq/baud_rate
  - half_bit = clks_per_bit/2

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
- rx_line  input  1  asynchronous serial input, idle high.
- data  output  8  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; data is valid in the same cycle.
- rx_busy  output  1  high from start-edge detection until return to IDLE.
- frame_err  output  1  one-cycle pulse when the sampled stop bit is 0.

Behaviour:
- Reset (reset_n=0 at a clk edge), from any state including mid-frame:
  - State = IDLE; clk_count = 0; bit_index = 0; shift register = 0.
  - data = 8'h00; rx_valid = 0; rx_busy = 0; frame_err = 0.
  - Synchroniser flops = 1.
- Synchroniser: 2-flop chain on rx_line. All decisions use the second-stage output rx_s, giving 2 cycles of latency.
- clk_count is 16 bits. clks_per_bit must satisfy 4 <= clks_per_bit <= 65535.
- State machine:
  - IDLE: rx_busy=0. When rx_s==0 → START, clk_count=0, rx_busy=1.
  - START: count until clk_count==half_bit-1.
    - rx_s==0 at that point → DATA, clk_count=0, bit_index=0.
    - rx_s==1 at that point → glitch: → IDLE, no outputs pulsed.
  - DATA: count to clks_per_bit-1, then sample rx_s.
    - Shift the sample in LSB first: shift = {rx_s, shift[7:1]}; clk_count=0.
    - bit_index increments; after bit_index 7 is sampled → STOP.
  - STOP: at clk_count==clks_per_bit-1, sample rx_s.
    - rx_s==1: data<=shift, rx_valid=1 for exactly one cycle, → IDLE.
    - rx_s==0: frame_err=1 for one cycle, data unchanged, → WAIT_IDLE.
  - WAIT_IDLE: rx_busy stays 1 until rx_s==1, then → IDLE. Prevents a break condition from retriggering as a start bit.
- Timing:
  - Return to IDLE happens at mid stop bit, so a start bit beginning at the nominal end of the stop bit is caught. Back-to-back frames are supported.
  - Sampling points are half_bit + k*clks_per_bit cycles after the synchronised falling edge, k = 1..9.
  - rx_valid asserts half_bit + 9*clks_per_bit + 2 cycles after the raw rx_line falling edge, ±1 cycle.
- rx_valid and frame_err are never high in the same cycle.
- No backpressure: the consumer must take data within one frame time. A new good frame overwrites data.

Decomposition:
- Shared package uart_pkg holds:
  - UART framing constants: DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
  - State encoding localparams: IDLE, START, DATA, STOP, WAIT_IDLE.
  - A function computing clks_per_bit.
  - The team's transmitter consumes the same constants.
- One natural sub-module: sync_2ff (1-bit, 2-flop synchroniser, reset value parameter, reset value 1 here).
- Everything else lives in uart_rx.

Test Plan:
Bench uses clk_freq=16, baud_rate=1, so clks_per_bit=16 and half_bit=8.
- Reset/idle: hold reset_n=0 for 3 cycles with rx_line=1 → data=8'h00, rx_valid=0, rx_busy=0, frame_err=0. Release → rx_busy stays 0.
- Single byte 8'hA5: drive 8N1 at 16 cycles/bit → exactly one rx_valid pulse, data=8'hA5, frame_err never 1. rx_busy falls in the same cycle as rx_valid.
- Back-to-back 8'h00 then 8'hFF, no idle gap → two rx_valid pulses 160 cycles apart, with data=8'h00 then 8'hFF.
- Glitch rejection: rx_line low for 4 cycles, then high → rx_busy pulses high, returns to 0 within 11 cycles, no rx_valid, no frame_err.
- Framing error: byte 8'h3C with stop bit 0, line held low 40 more cycles, then high → one frame_err pulse, data keeps previous value, rx_busy stays 1 until the line goes high, no spurious start. A following good 8'h42 → rx_valid with data=8'h42.
- Reset mid-frame: assert reset_n=0 during data bit 4 of 8'h81 → next cycle all outputs at reset values, no rx_valid. The next full frame 8'h81 is received correctly. Also loop back through the team's transmitter with 256 sequential bytes → all match.
